wave_port_dispatch: RTL
=======================

// Module: wave_port_dispatch
// PURPOSE
//  Timed wave-command queue downstream of the tProc register bank. Each push
//  carries a port index, an absolute timestamp (out_time) and the 168-bit wave
//  word (out_wreg). Entries are released in FIFO order when the timestamp is
//  due against the running time base. Delivery to the selected output port
//  uses a valid/ready handshake. Late releases and queue overflow are reported.
// PARAMETERS
//  FIFO_AW   2   log2 of queue depth (DEPTH = 2**FIFO_AW entries)
//  PORT_AW   4   width of output port index
// PORTS
//  clk_i         in   1        clock
//  rst_ni        in   1        reset, synchronous, active-low
//  clear_i       in   1        synchronous flush of queue, FSM and status
//  time_abs_i    in   32       running absolute time base
//  push_i        in   1        push request (single-cycle pulse per entry)
//  push_port_i   in   PORT_AW  destination port of pushed entry
//  push_time_i   in   32       release timestamp of pushed entry
//  push_wave_i   in   168      wave word of pushed entry
//  full_o        out  1        count == DEPTH (registered)
//  empty_o       out  1        count == 0 (registered)
//  cnt_o         out  FIFO_AW+1  entries currently queued
//  port_vld_o    out  1        output entry valid
//  port_rdy_i    in   1        destination port accepts entry
//  port_sel_o    out  PORT_AW  port index of output entry
//  port_dt_o     out  168      wave word of output entry
//  late_cnt_o    out  16       count of entries released after their due time
//  ovf_o         out  1        sticky: a push was dropped because queue was full
// BEHAVIOUR
//  - Single clock clk_i; rst_ni synchronous active-low. Priority: rst_ni low >
//    clear_i > normal operation.
//  - Reset/clear values: cnt_o=0, empty_o=1, full_o=0, port_vld_o=0,
//    port_sel_o=0, port_dt_o=0, late_cnt_o=0, ovf_o=0, FSM=ST_IDLE, pointers 0.
//  - Queue: circular buffer of DEPTH entries {port,time,wave}; wr/rd pointers
//    FIFO_AW bits, wrap modulo DEPTH; cnt tracked separately (0..DEPTH).
//  - Push accepted iff push_i && !full_o (registered value). Push while full
//    is dropped, sets ovf_o (sticky until reset/clear). Push and pop in the
//    same cycle: both performed, cnt unchanged; full queue never accepts push
//    even if a pop occurs that cycle.
//  - Due test: diff = time_abs_i - head_time, 32-bit modulo, read as signed.
//    Due iff diff >= 0 (handles wrap of time base, window +/- 2^31).
//  - FSM states:
//    ST_IDLE : cnt==0 -> stay; cnt!=0 -> ST_WAIT next edge.
//    ST_WAIT : head not due -> stay. Head due -> on that edge load
//              port_sel_o/port_dt_o from head, pop head, port_vld_o<=1,
//              late_cnt_o += (diff>0) saturating at 16'hFFFF, -> ST_ISSUE.
//    ST_ISSUE: port_vld_o, port_sel_o, port_dt_o held stable while
//              port_rdy_i=0. On port_vld_o && port_rdy_i: port_vld_o<=0,
//              -> ST_WAIT if cnt!=0 else ST_IDLE.
//  - Latency: push sampled at edge E into empty queue with due timestamp ->
//    port_vld_o high after edge E+2. Max throughput 1 entry per 2 cycles.
//  - port_sel_o/port_dt_o keep last issued value after handshake.
//  - clear_i or reset during ST_ISSUE abandons the in-flight entry:
//    port_vld_o=0 after that edge, no handshake completed.
//  - time_abs_i only compared, never stored; jumps in time base permitted.
// TESTING
//  1 Reset held 2 cycles -> all outputs at reset values, empty_o=1, cnt_o=0.
//  2 time_abs=90 incrementing, push port=3 time=100 wave=168'hA5 -> port_vld_o
//    rises on edge after time_abs_i=100 sampled, port_sel_o=3, late_cnt_o=0.
//  3 time_abs=80, push time=50, port_rdy_i=1 -> entry issued, late_cnt_o=1,
//    handshake completes, FSM returns ST_IDLE, empty_o=1.
//  4 FIFO_AW=2, push 5 entries time=32'h7000_0000 at time_abs=0 -> cnt_o=4,
//    full_o=1, 5th dropped, ovf_o=1; no port_vld_o.
//  5 Wrap: time_abs=32'hFFFF_FFF0, push time=32'h0000_0010 -> not issued
//    until time_abs_i reaches 32'h0000_0010; late_cnt_o=0.
//  6 Issue entry, port_rdy_i=0 5 cycles -> vld/sel/dt stable; assert clear_i
//    -> port_vld_o=0 next edge, cnt_o=0, ovf_o=0, late_cnt_o=0.

Source files
------------

// File: rtl/wave_port_dispatch.sv
// Timed wave-command queue: entries are held in FIFO order until their
// timestamp is due against the running time base. Each due entry is then
// presented to its destination port through a valid/ready handshake.
module wave_port_dispatch #(
    parameter int unsigned FIFO_AW = 2,
    parameter int unsigned PORT_AW = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic [31:0]        time_abs_i,
    input  logic               push_i,
    input  logic [PORT_AW-1:0] push_port_i,
    input  logic [31:0]        push_time_i,
    input  logic [167:0]       push_wave_i,
    output logic               full_o,
    output logic               empty_o,
    output logic [FIFO_AW:0]   cnt_o,
    output logic               port_vld_o,
    input  logic               port_rdy_i,
    output logic [PORT_AW-1:0] port_sel_o,
    output logic [167:0]       port_dt_o,
    output logic [15:0]        late_cnt_o,
    output logic               ovf_o
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;
    localparam int unsigned TW    = 32;
    localparam int unsigned WW    = 168;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [PORT_AW-1:0] port_mem [DEPTH];
    logic [TW-1:0]      time_mem [DEPTH];
    logic [WW-1:0]      wave_mem [DEPTH];

    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;

    logic [TW-1:0]      diff;
    logic               due;
    logic               late;
    logic               push_ok;
    logic               pop;
    logic               done;
    logic [CW-1:0]      cnt_nxt;

    // Head timestamp comparison, modulo 2^32 so a wrapping time base works.
    always_comb begin
        diff = time_abs_i - time_mem[rd_ptr];
        due  = ~diff[TW-1];
        late = due && (diff != '0);
    end

    // State register; clear has the same effect as reset on the sequencer.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else if (clear_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: wait for a queued head, issue it when due, then drain.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cnt_o != '0) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (pop) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (done) begin
                    state_nxt = (cnt_o != '0) ? ST_WAIT : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Control strobes decoded from the current state and queue status.
    always_comb begin
        push_ok = 1'b0;
        pop     = 1'b0;
        done    = 1'b0;
        push_ok = push_i && !full_o;
        pop     = (state == ST_WAIT) && due && !empty_o;
        done    = (state == ST_ISSUE) && port_vld_o && port_rdy_i;
        cnt_nxt = cnt_o + CW'(push_ok) - CW'(pop);
    end

    // Queue storage; contents need no reset since pointers/count gate reads.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            port_mem[wr_ptr] <= push_port_i;
            time_mem[wr_ptr] <= push_time_i;
            wave_mem[wr_ptr] <= push_wave_i;
        end
    end

    // Pointers, status flags and the registered output port.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt_o      <= '0;
            empty_o    <= 1'b1;
            full_o     <= 1'b0;
            ovf_o      <= 1'b0;
            port_vld_o <= 1'b0;
            port_sel_o <= '0;
            port_dt_o  <= '0;
            late_cnt_o <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (push_i && full_o) begin
                ovf_o <= 1'b1;
            end
            cnt_o   <= cnt_nxt;
            empty_o <= (cnt_nxt == '0);
            full_o  <= (cnt_nxt == CW'(DEPTH));
            if (pop) begin
                rd_ptr     <= rd_ptr + FIFO_AW'(1);
                port_sel_o <= port_mem[rd_ptr];
                port_dt_o  <= wave_mem[rd_ptr];
                port_vld_o <= 1'b1;
                if (late && (late_cnt_o != 16'hFFFF)) begin
                    late_cnt_o <= late_cnt_o + 16'd1;
                end
            end else if (done) begin
                port_vld_o <= 1'b0;
            end
        end
    end

endmodule
